tdoa_capture: RTL and testbench

Front-end timing block that produces the time-difference-of-arrival inputs consumed by `localizer_2`. It timestamps the first rising edge on each of four microphone-detector lines: channel 0 is the reference and channels 1–3 are the others. It then emits `tau1`, `tau2` and `tau3` as 34-bit signed clock-tick differences, each equal to the channel's timestamp minus the channel 0 timestamp, together with a valid/ready handshake. It sits between the analog threshold detectors and the localizer's `tau*` ports.

---
 rtl/tdoa_capture.sv | 130 +++++++++++++
 tb/tb_tdoa_capture.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/tdoa_capture.sv
// Four-channel first-edge timestamper; emits signed tick differences t1-t0, t2-t0, t3-t0
// with a valid/ready handshake and a bounded capture window.
module tdoa_capture #(
  parameter int unsigned WIN_MAX = 1000000,
  parameter int unsigned CNT_W   = 20
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               arm,
  input  logic [3:0]         mic,
  output logic signed [33:0] tau1,
  output logic signed [33:0] tau2,
  output logic signed [33:0] tau3,
  output logic               valid,
  input  logic               ready,
  output logic               timeout,
  output logic               busy
);

  typedef enum logic [2:0] {StIdle, StArmed, StCapture, StCalc, StValid} state_e;

  localparam logic [CNT_W-1:0] WinMax = CNT_W'(WIN_MAX);

  state_e             state_q;
  logic [3:0]         sync1_q, sync2_q, sync3_q, edge_q;
  logic [3:0]         seen_q;
  logic [3:0]         fresh, seen_all;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   stamp_q [4];
  logic signed [33:0] tau1_q, tau2_q, tau3_q;
  logic               valid_q, timeout_q, busy_q;

  // Identical synchronizer depth on every channel, so its latency cancels in the differences.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      edge_q  <= '0;
    end else begin
      sync1_q <= mic;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q & ~sync3_q;
    end
  end

  always_comb begin
    fresh    = edge_q & ~seen_q;
    seen_all = seen_q | edge_q;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      seen_q    <= '0;
      for (int i = 0; i < 4; i++) stamp_q[i] <= '0;
      tau1_q    <= '0;
      tau2_q    <= '0;
      tau3_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (arm) begin
            seen_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) stamp_q[i] <= '0;
            busy_q  <= 1'b1;
            state_q <= StArmed;
          end
        end
        StArmed: begin
          if (|edge_q) begin
            seen_q <= edge_q;
            for (int i = 0; i < 4; i++) begin
              if (edge_q[i]) stamp_q[i] <= '0;
            end
            cnt_q   <= CNT_W'(1);
            state_q <= (&edge_q) ? StCalc : StCapture;
          end
        end
        StCapture: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (&seen_q) begin
            state_q <= StCalc;
          end else begin
            seen_q <= seen_all;
            for (int i = 0; i < 4; i++) begin
              if (fresh[i]) stamp_q[i] <= cnt_q;
            end
            // A last edge landing in the final window cycle still completes the capture.
            if ((cnt_q == WinMax) && !(&seen_all)) begin
              timeout_q <= 1'b1;
              busy_q    <= 1'b0;
              state_q   <= StIdle;
            end
          end
        end
        StCalc: begin
          tau1_q  <= $signed(34'(stamp_q[1])) - $signed(34'(stamp_q[0]));
          tau2_q  <= $signed(34'(stamp_q[2])) - $signed(34'(stamp_q[0]));
          tau3_q  <= $signed(34'(stamp_q[3])) - $signed(34'(stamp_q[0]));
          valid_q <= 1'b1;
          state_q <= StValid;
        end
        StValid: begin
          if (ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign tau1    = tau1_q;
  assign tau2    = tau2_q;
  assign tau3    = tau3_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tdoa_capture.sv
// Directed bench for tdoa_capture: table of edge-offset vectors plus hand-written sequences
// for timeout, backpressure and mid-capture reset.
module tb_tdoa_capture;

  logic               Clock = 1'b0;
  logic               Reset = 1'b1;
  logic               arm = 1'b0, arm_t = 1'b0, ready = 1'b0;
  logic [3:0]         mic = 4'h0;
  logic signed [33:0] tau1, tau2, tau3, tau1_t, tau2_t, tau3_t;
  logic               valid, timeout, busy, valid_t, timeout_t, busy_t;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clock = ~Clock;

  tdoa_capture dut (
    .Clock(Clock), .Reset(Reset), .arm(arm), .mic(mic),
    .tau1(tau1), .tau2(tau2), .tau3(tau3),
    .valid(valid), .ready(ready), .timeout(timeout), .busy(busy)
  );

  tdoa_capture #(.WIN_MAX(500)) dut_t (
    .Clock(Clock), .Reset(Reset), .arm(arm_t), .mic(mic),
    .tau1(tau1_t), .tau2(tau2_t), .tau3(tau3_t),
    .valid(valid_t), .ready(ready), .timeout(timeout_t), .busy(busy_t)
  );

  typedef struct {
    string name;
    int    d0, d1, d2, d3;  // cycle offset at which each mic rises
    int    e1, e2, e3;      // expected taus
    int    lat;             // cycles from last mic rise to valid
    bit    rep;             // re-pulse mic0 during capture
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_capture(input vec_t v);
    int dl [4];
    int k;
    int dmax;
    dl = '{v.d0, v.d1, v.d2, v.d3};
    dmax = 0;
    for (int i = 0; i < 4; i++) if (dl[i] > dmax) dmax = dl[i];
    arm = 1'b1;
    @(negedge Clock);
    arm = 1'b0;
    chk({v.name, " busy after arm"}, longint'(busy), 1);
    k = 0;
    while (k < 20000) begin
      for (int i = 0; i < 4; i++) if (k == dl[i]) mic[i] = 1'b1;
      if (v.rep && (k == 5 || k == 15)) mic[0] = 1'b0;
      if (v.rep && (k == 10 || k == 20)) mic[0] = 1'b1;
      @(negedge Clock);
      k++;
      if (valid) break;
    end
    chk({v.name, " latency"}, longint'(k - dmax), longint'(v.lat));
    chk({v.name, " tau1"}, longint'(tau1), longint'(v.e1));
    chk({v.name, " tau2"}, longint'(tau2), longint'(v.e2));
    chk({v.name, " tau3"}, longint'(tau3), longint'(v.e3));
  endtask

  task automatic accept(input string name);
    ready = 1'b1;
    @(negedge Clock);
    ready = 1'b0;
    chk({name, " valid after accept"}, longint'(valid), 0);
    chk({name, " busy after accept"}, longint'(busy), 0);
    mic = 4'h0;
    repeat (6) @(negedge Clock);
  endtask

  initial begin
    int k;
    int saw_valid;
    vecs[0] = '{"basic",   0,     100,  250, 40,   100,   250,    40,    6, 1'b0};
    vecs[1] = '{"reflast", 10898, 3327, 0,   4274, -7571, -10898, -6624, 6, 1'b0};
    vecs[2] = '{"simul",   0,     0,    0,   0,    0,     0,      0,     5, 1'b0};
    vecs[3] = '{"repeat0", 0,     30,   40,  50,   30,    40,     50,    6, 1'b1};
    vecs[4] = '{"mixed",   7,     5,    0,   7,    -2,    -7,     0,     6, 1'b0};

    #3;
    chk("reset valid", longint'(valid), 0);
    chk("reset busy", longint'(busy), 0);
    chk("reset timeout", longint'(timeout), 0);
    chk("reset tau1", longint'(tau1), 0);
    #9 Reset = 1'b0;
    @(negedge Clock);
    chk("busy after release", longint'(busy), 0);
    chk("valid idle", longint'(valid), 0);

    for (int i = 0; i < 5; i++) begin
      run_capture(vecs[i]);
      accept(vecs[i].name);
    end

    // Backpressure: results held while extra edges and arm pulses arrive.
    run_capture(vecs[0]);
    for (int j = 0; j < 20; j++) begin
      arm = (j % 5 == 0);
      mic = j[0] ? 4'hF : 4'h0;
      @(negedge Clock);
      chk("bp valid held", longint'(valid), 1);
      chk("bp tau1 held", longint'(tau1), 100);
      chk("bp tau2 held", longint'(tau2), 250);
      chk("bp tau3 held", longint'(tau3), 40);
    end
    arm = 1'b0;
    mic = 4'h0;
    accept("bp");
    chk("bp arm not queued", longint'(busy), 0);

    // Reset during capture aborts with no result.
    arm = 1'b1;
    @(negedge Clock);
    arm = 1'b0;
    mic[0] = 1'b1;
    repeat (20) @(negedge Clock);
    chk("abort busy before", longint'(busy), 1);
    #2 Reset = 1'b1;
    #1;
    chk("abort busy", longint'(busy), 0);
    chk("abort valid", longint'(valid), 0);
    chk("abort tau1", longint'(tau1), 0);
    chk("abort timeout", longint'(timeout), 0);
    @(negedge Clock);
    Reset = 1'b0;
    mic = 4'h0;
    saw_valid = 0;
    repeat (8) begin
      @(negedge Clock);
      if (valid || timeout) saw_valid = 1;
    end
    chk("abort no output", longint'(saw_valid), 0);
    chk("abort busy after", longint'(busy), 0);
    run_capture(vecs[4]);
    accept("post abort");

    // Timeout on the short-window instance: mic3 never rises.
    arm_t = 1'b1;
    @(negedge Clock);
    arm_t = 1'b0;
    chk("to busy after arm", longint'(busy_t), 1);
    k = 0;
    saw_valid = 0;
    while (k < 1000) begin
      if (k == 0) mic[0] = 1'b1;
      if (k == 10) mic[1] = 1'b1;
      if (k == 20) mic[2] = 1'b1;
      @(negedge Clock);
      k++;
      if (valid_t) saw_valid = 1;
      if (timeout_t) break;
    end
    chk("to timeout cycle", longint'(k), 504);
    @(negedge Clock);
    chk("to pulse width", longint'(timeout_t), 0);
    chk("to busy after", longint'(busy_t), 0);
    chk("to no valid", longint'(saw_valid | valid_t), 0);
    chk("main dut untouched", longint'(busy), 0);
    mic = 4'h0;
    repeat (4) @(negedge Clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
